// File: rtl/anabellek_gecikmeli.sv
// anabellek_gecikmeli: main memory model for the multicycle processor.
// Word-addressed storage behind a valid/ready request/response port, with
// a fixed access latency, byte-masked writes and an error response for
// out-of-range or misaligned addresses. One request is outstanding at a time.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   istek_gecerli  request valid          istek_hazir    request ready
//   adres          request byte address   yaz            1 = write, 0 = read
//   yaz_veri       write data             yaz_maske      byte write enables
//   cevap_gecerli  response valid         cevap_hazir    response ready
//   oku_veri       response data          hata           response error flag
//   okuma_sayisi / yazma_sayisi / hata_sayisi  (only with ANABELLEK_ISTATISTIK_EN)
//                  saturating counts of read / write / error responses
//
// Optional feature macro: ANABELLEK_ISTATISTIK_EN adds the response counters.
// The storage array is the element `bellek`, reachable hierarchically for
// preload and peek.
module anabellek_gecikmeli #(
  parameter int unsigned          ADRES_BIT    = 32,
  parameter int unsigned          VERI_BIT     = 32,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = ADRES_BIT'(32'h8000_0000),
  parameter int unsigned          SATIR_SAYISI = 1024,
  parameter int unsigned          GECIKME      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  istek_gecerli,
  output logic                  istek_hazir,
  input  logic [ADRES_BIT-1:0]  adres,
  input  logic                  yaz,
  input  logic [VERI_BIT-1:0]   yaz_veri,
  input  logic [VERI_BIT/8-1:0] yaz_maske,
`ifdef ANABELLEK_ISTATISTIK_EN
  output logic [31:0]           okuma_sayisi,
  output logic [31:0]           yazma_sayisi,
  output logic [31:0]           hata_sayisi,
`endif
  output logic                  cevap_gecerli,
  input  logic                  cevap_hazir,
  output logic [VERI_BIT-1:0]   oku_veri,
  output logic                  hata
);

  localparam int unsigned BAYT_SAYISI = VERI_BIT / 8;
  localparam int unsigned OFS_BIT     = $clog2(BAYT_SAYISI);
  localparam int unsigned IDX_BIT     = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam int unsigned SAYAC_BIT   = (GECIKME > 2) ? $clog2(GECIKME - 1) : 1;

  localparam logic [ADRES_BIT-1:0] HIZA_MASKE  = ADRES_BIT'((64'd1 << OFS_BIT) - 64'd1);
  localparam logic [ADRES_BIT:0]   SATIR_SINIR = (ADRES_BIT + 1)'(SATIR_SAYISI);
  localparam logic [SAYAC_BIT-1:0] SAYAC_YUK   = SAYAC_BIT'((GECIKME > 1) ? GECIKME - 2 : 0);

  typedef enum logic [1:0] {BOSTA, BEKLE, CEVAP} durum_e;

  logic [VERI_BIT-1:0] bellek [SATIR_SAYISI];

  durum_e                r_durum, w_durum_sonraki;
  logic [SAYAC_BIT-1:0]  r_sayac, w_sayac_sonraki;
  logic [ADRES_BIT-1:0]  r_adres;
  logic                  r_yaz;
  logic [VERI_BIT-1:0]   r_veri;
  logic [BAYT_SAYISI-1:0] r_maske;
  logic [VERI_BIT-1:0]   r_oku_veri;
  logic                  r_hata;

  logic                   w_kabul;
  logic                   w_erisim;
  logic [ADRES_BIT-1:0]   w_e_adres;
  logic                   w_e_yaz;
  logic [VERI_BIT-1:0]    w_e_veri;
  logic [BAYT_SAYISI-1:0] w_e_maske;
  logic [ADRES_BIT-1:0]   w_fark;
  logic [ADRES_BIT-1:0]   w_idx_tam;
  logic [IDX_BIT-1:0]     w_idx;
  logic                   w_gecerli_adres;
  logic [VERI_BIT-1:0]    w_satir;
  logic [VERI_BIT-1:0]    w_birlesik;

  assign w_kabul = (r_durum == BOSTA) && istek_gecerli;

  // Array access happens on the edge entering CEVAP. With GECIKME=1 that is
  // the accept edge itself, so the live inputs are used instead of the latches.
  assign w_erisim  = (w_durum_sonraki == CEVAP) && (r_durum != CEVAP);
  assign w_e_adres = (r_durum == BOSTA) ? adres     : r_adres;
  assign w_e_yaz   = (r_durum == BOSTA) ? yaz       : r_yaz;
  assign w_e_veri  = (r_durum == BOSTA) ? yaz_veri  : r_veri;
  assign w_e_maske = (r_durum == BOSTA) ? yaz_maske : r_maske;

  // The explicit >= check keeps a wrapped subtraction from aliasing onto a row.
  assign w_fark          = w_e_adres - BELLEK_ADRES;
  assign w_idx_tam       = w_fark >> OFS_BIT;
  assign w_idx           = w_idx_tam[IDX_BIT-1:0];
  assign w_gecerli_adres = (w_e_adres >= BELLEK_ADRES) &&
                           ({1'b0, w_idx_tam} < SATIR_SINIR) &&
                           ((w_e_adres & HIZA_MASKE) == '0);
  assign w_satir         = bellek[w_idx];

  always_comb begin
    w_birlesik = w_satir;
    for (int i = 0; i < BAYT_SAYISI; i++) begin
      if (w_e_maske[i]) w_birlesik[8*i +: 8] = w_e_veri[8*i +: 8];
    end
  end

  always_comb begin
    w_durum_sonraki = r_durum;
    w_sayac_sonraki = r_sayac;
    unique case (r_durum)
      BOSTA: begin
        if (istek_gecerli) begin
          if (GECIKME == 1) begin
            w_durum_sonraki = CEVAP;
          end else begin
            w_durum_sonraki = BEKLE;
            w_sayac_sonraki = SAYAC_YUK;
          end
        end
      end
      BEKLE: begin
        if (r_sayac == '0) w_durum_sonraki = CEVAP;
        else               w_sayac_sonraki = r_sayac - 1'b1;
      end
      CEVAP: begin
        if (cevap_hazir) w_durum_sonraki = BOSTA;
      end
      default: w_durum_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_durum    <= BOSTA;
      r_sayac    <= '0;
      r_adres    <= '0;
      r_yaz      <= 1'b0;
      r_veri     <= '0;
      r_maske    <= '0;
      r_oku_veri <= '0;
      r_hata     <= 1'b0;
    end else begin
      r_durum <= w_durum_sonraki;
      r_sayac <= w_sayac_sonraki;
      if (w_kabul) begin
        r_adres <= adres;
        r_yaz   <= yaz;
        r_veri  <= yaz_veri;
        r_maske <= yaz_maske;
      end
      if (w_erisim) begin
        r_hata     <= !w_gecerli_adres;
        r_oku_veri <= !w_gecerli_adres ? '0 : (w_e_yaz ? w_birlesik : w_satir);
      end
    end
  end

  // Storage is never cleared; the rst gate stops a write while reset is held.
  always_ff @(posedge clk) begin
    if (rst && w_erisim && w_e_yaz && w_gecerli_adres) begin
      bellek[w_idx] <= w_birlesik;
    end
  end

  assign istek_hazir   = (r_durum == BOSTA);
  assign cevap_gecerli = (r_durum == CEVAP);
  assign oku_veri      = r_oku_veri;
  assign hata          = r_hata;

`ifdef ANABELLEK_ISTATISTIK_EN
  logic        w_el_sikisma;
  logic [31:0] r_okuma_sayisi, r_yazma_sayisi, r_hata_sayisi;

  assign w_el_sikisma = (r_durum == CEVAP) && cevap_hazir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_okuma_sayisi <= '0;
      r_yazma_sayisi <= '0;
      r_hata_sayisi  <= '0;
    end else if (w_el_sikisma) begin
      if (r_hata) begin
        if (r_hata_sayisi != '1) r_hata_sayisi <= r_hata_sayisi + 32'd1;
      end else if (r_yaz) begin
        if (r_yazma_sayisi != '1) r_yazma_sayisi <= r_yazma_sayisi + 32'd1;
      end else begin
        if (r_okuma_sayisi != '1) r_okuma_sayisi <= r_okuma_sayisi + 32'd1;
      end
    end
  end

  assign okuma_sayisi = r_okuma_sayisi;
  assign yazma_sayisi = r_yazma_sayisi;
  assign hata_sayisi  = r_hata_sayisi;
`endif

endmodule
